// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared defaults, HALT opcode and FSM state type for the fetch unit
package instr_fetch_pkg;

    localparam int DEF_INSTR_WIDTH = 20;
    localparam int DEF_PC_BITS     = 5;
    localparam int DEF_ISSUE_GAP   = 4;

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_GAP,
        ST_DONE
    } fetch_state_t;

    // Top nibble of an instruction word selects HALT.
    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == HALT_OP;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - control, load and issue handshake bundle between fetch unit and its host
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int PC_BITS     = DEF_PC_BITS
);
    logic                   load_en;
    logic [PC_BITS-1:0]     load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   start;
    logic                   stop;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [PC_BITS-1:0]     pc;
    logic                   busy;
    logic                   done;

    modport master (
        output load_en, load_addr, load_data, start, stop, instr_ready,
        input  instruction, instr_valid, pc, busy, done
    );

    modport slave (
        input  load_en, load_addr, load_data, start, stop, instr_ready,
        output instruction, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - program memory, synchronous write and synchronous (read-old) read
module instr_mem
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int PC_BITS     = DEF_PC_BITS
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [PC_BITS-1:0]     wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic [PC_BITS-1:0]     rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data
);
    logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

    // Contents are deliberately not reset; a program survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch/issue FSM with program counter and inter-issue gap counter
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int PC_BITS     = DEF_PC_BITS,
    parameter int ISSUE_GAP   = DEF_ISSUE_GAP
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.slave  bus
);
    localparam logic [3:0]         GAP_LOAD = 4'(ISSUE_GAP > 1 ? ISSUE_GAP - 2 : 0);
    localparam logic [PC_BITS-1:0] PC_ONE   = 1;

    fetch_state_t           state;
    logic [3:0]             gap_cnt;
    logic                   first_fetch;
    logic [PC_BITS-1:0]     pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   mem_wr_en;
    logic                   handshake;
    logic [PC_BITS-1:0]     rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;

    // Loads are only honoured while the fetch engine is parked.
    assign mem_wr_en = bus.load_en && (state == ST_IDLE || state == ST_DONE);
    assign handshake = (state == ST_ISSUE) && bus.instr_ready && !bus.stop;
    // Read ahead at the incremented pc on a handshake so a gap-less
    // configuration still sees the next word on entering FETCH.
    assign rd_addr   = handshake ? pc_q + PC_ONE : pc_q;

    instr_mem #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_BITS     (PC_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (bus.load_addr),
        .wr_data (bus.load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Control FSM; every output is registered alongside its state change.
    // The first FETCH after start spends one extra cycle re-reading address 0
    // so that a word loaded in the same cycle as start is the one issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            first_fetch <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (bus.stop) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            first_fetch <= 1'b0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state       <= ST_FETCH;
                        pc_q        <= '0;
                        first_fetch <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (first_fetch) begin
                        first_fetch <= 1'b0;
                    end else if (is_halt(rd_data[INSTR_WIDTH-1 -: 4])) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state   <= ST_ISSUE;
                        instr_q <= rd_data;
                        valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.instr_ready) begin
                        pc_q    <= pc_q + PC_ONE;
                        instr_q <= '0;
                        valid_q <= 1'b0;
                        if (ISSUE_GAP > 1) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= ST_FETCH;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a program-walk reference model
module tb_instr_fetch;
    localparam int IW    = 20;
    localparam int PB    = 5;
    localparam int GAP   = 4;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [IW-1:0] model_mem [DEPTH];
    int            model_pc;
    logic [IW-1:0] newv;

    instr_fetch_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus ();

    instr_fetch #(
        .INSTR_WIDTH (IW),
        .PC_BITS     (PB),
        .ISSUE_GAP   (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        w = IW'($urandom);
        if (w[IW-1 -: 4] == 4'hF) w[IW-1 -: 4] = 4'($urandom_range(0, 14));
        return w;
    endfunction

    // Index of the first HALT word reachable from address 0.
    function automatic int halt_index();
        for (int i = 0; i < DEPTH; i++) begin
            if (model_mem[i][IW-1 -: 4] == 4'hF) return i;
        end
        return -1;
    endfunction

    task automatic load_word(input int a, input logic [IW-1:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = PB'(a);
        bus.load_data = d;
        step();
        bus.load_en   = 1'b0;
        model_mem[a]  = d;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.instr_valid && n < budget) begin
            step();
            n++;
        end
        check("wait_valid", 32'(bus.instr_valid), 32'd1);
    endtask

    // Expects n issues with instr_ready high; each word must follow the model
    // program walk and issues must be GAP+1 cycles apart. With chk_lat the
    // first issue must appear two edges after the start edge.
    task automatic run_issues(input int n, input bit chk_lat);
        int issued = 0;
        int cyc    = 0;
        int last   = 0;
        int budget = n * (GAP + 1) + 10;
        while (issued < n && cyc < budget) begin
            step();
            cyc++;
            if (bus.instr_valid) begin
                check("issue_word", 32'(bus.instruction), 32'(model_mem[model_pc]));
                if (issued > 0) check("issue_interval", 32'(cyc - last), 32'(GAP + 1));
                else if (chk_lat) check("start_latency", 32'(cyc), 32'd2);
                last     = cyc;
                model_pc = (model_pc + 1) % DEPTH;
                issued++;
            end
        end
        check("issue_count", 32'(issued), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        bit saw_valid = 1'b0;
        while (!bus.done && n < budget) begin
            step();
            n++;
            if (bus.instr_valid) saw_valid = 1'b1;
        end
        check("done", 32'(bus.done), 32'd1);
        check("halt_not_issued", 32'(saw_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.instr_ready = 1'b0;
        step();
        step();
        check("rst_instruction", 32'(bus.instruction), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b1;
        step();

        // Two-word program terminated by HALT.
        load_word(0, 20'h12345);
        load_word(1, 20'h0A0B0);
        load_word(2, 20'hF0000);
        bus.instr_ready = 1'b1;
        model_pc = 0;
        pulse_start();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        run_issues(halt_index(), 1'b1);
        wait_done(20);
        check("halt_pc", 32'(bus.pc), 32'(model_pc));
        check("halt_busy", 32'(bus.busy), 32'd0);

        // Back-pressure: instruction holds while instr_ready is low.
        for (int i = 0; i < 5; i++) load_word(i, rand_word());
        bus.instr_ready = 1'b0;
        pulse_start();
        check("start_clears_done", 32'(bus.done), 32'd0);
        wait_valid(10);
        check("hold_first", 32'(bus.instruction), 32'(model_mem[0]));
        for (int i = 0; i < 6; i++) begin
            step();
            check("hold_valid", 32'(bus.instr_valid), 32'd1);
            check("hold_word", 32'(bus.instruction), 32'(model_mem[0]));
            check("hold_pc", 32'(bus.pc), 32'd0);
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check("post_hs_valid", 32'(bus.instr_valid), 32'd0);
        check("post_hs_zero", 32'(bus.instruction), 32'd0);
        check("post_hs_pc", 32'(bus.pc), 32'd1);
        wait_valid(10);
        check("single_handshake", 32'(bus.instruction), 32'(model_mem[1]));
        pulse_stop();

        // No HALT anywhere: pc wraps and the 33rd issue is mem[0] again.
        for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
        bus.instr_ready = 1'b1;
        model_pc = 0;
        pulse_start();
        run_issues(DEPTH, 1'b1);
        check("pc_before_wrap", 32'(bus.pc), 32'(DEPTH - 1));
        step();
        check("pc_wrap", 32'(bus.pc), 32'd0);
        run_issues(1, 1'b0);
        pulse_stop();

        // stop and start together while issuing.
        model_pc = 0;
        pulse_start();
        run_issues(1, 1'b1);
        step();
        bus.instr_ready = 1'b0;
        wait_valid(10);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("stop_valid", 32'(bus.instr_valid), 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_zero", 32'(bus.instruction), 32'd0);
        check("stop_pc", 32'(bus.pc), 32'd1);
        step();
        check("stop_beats_start", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of GAP.
        bus.instr_ready = 1'b1;
        model_pc = 0;
        pulse_start();
        run_issues(1, 1'b1);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("async_valid", 32'(bus.instr_valid), 32'd0);
        check("async_zero", 32'(bus.instruction), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_pc", 32'(bus.pc), 32'd0);
        check("async_done", 32'(bus.done), 32'd0);
        #1 rst = 1'b1;
        step();
        model_pc = 0;
        pulse_start();
        run_issues(1, 1'b1);
        pulse_stop();

        // Load while busy is dropped.
        bus.instr_ready = 1'b0;
        pulse_start();
        wait_valid(10);
        bus.load_en   = 1'b1;
        bus.load_addr = '0;
        bus.load_data = 20'h00001;
        step();
        bus.load_en = 1'b0;
        pulse_stop();
        bus.instr_ready = 1'b1;
        model_pc = 0;
        pulse_start();
        run_issues(1, 1'b1);
        pulse_stop();

        // Load and start in the same idle cycle: new word is fetched first.
        newv = rand_word();
        bus.load_en   = 1'b1;
        bus.load_addr = '0;
        bus.load_data = newv;
        bus.start     = 1'b1;
        model_mem[0]  = newv;
        step();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        model_pc = 0;
        run_issues(2, 1'b1);
        pulse_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
